// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks (adder and subtractor).
// The state codes are fixed so that both FSMs decode identically downstream.
package serial_arith_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_SUB  = SUB,
        S_DONE = DONE
    } state_t;

endpackage

// File: rtl/sub_serial_if.sv
// Operand/result bundle of the bit-serial subtractor.
// The master side starts or acknowledges with en; the slave side returns the result.
interface sub_serial_if #(
    parameter int WIDTH = serial_arith_pkg::DEF_WIDTH
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             done;

    modport master (
        output en, a, b,
        input  out, borrow, done
    );

    modport slave (
        input  en, a, b,
        output out, borrow, done
    );
endinterface

// File: rtl/serial_full_sub.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
module serial_full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b, LSB first, one bit per clock through a
// single borrow flop. The result and final borrow hold in DONE until en is seen.
module sub_serial
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    sub_serial_if.slave   bus
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("sub_serial: WIDTH must be at least 2");
        end
    endgenerate

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             br;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] out_reg;
    logic             borrow_reg;

    logic             load;
    logic             shift;
    logic             last;
    logic             diff_bit;
    logic             borrow_bit;

    // Datapath enables decoded straight from the state register; an illegal
    // code asserts neither, so it falls back to IDLE without touching data.
    assign load  = (state == S_IDLE) && bus.en;
    assign shift = (state == S_SUB);
    assign last  = shift && (count == LAST);

    serial_full_sub u_full_sub (
        .x    (a_reg[0]),
        .y    (b_reg[0]),
        .bin  (br),
        .d    (diff_bit),
        .bout (borrow_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (bus.en) next_state = S_SUB;
            S_SUB:   if (count == LAST) next_state = S_DONE;
            S_DONE:  if (bus.en) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (load) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
        end else if (shift) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br <= 1'b0;
        end else if (load) begin
            br <= 1'b0;
        end else if (shift) begin
            br <= borrow_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (shift) begin
            count <= count + CW'(1);
        end
    end

    // Result enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= '0;
        end else if (load) begin
            out_reg <= '0;
        end else if (shift) begin
            out_reg <= {diff_bit, out_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            borrow_reg <= 1'b0;
        end else if (load) begin
            borrow_reg <= 1'b0;
        end else if (last) begin
            borrow_reg <= borrow_bit;
        end
    end

    assign bus.out    = out_reg;
    assign bus.borrow = borrow_reg;
    assign bus.done   = (state == S_DONE);

    count_in_range: assert property (@(posedge clk) disable iff (rst)
        (state == S_SUB) |-> (count <= LAST));

    done_holds_result: assert property (@(posedge clk) disable iff (rst)
        (state == S_DONE && !bus.en) |=> ($stable(out_reg) && $stable(borrow_reg)));

endmodule

// File: tb/tb_sub_serial.sv
// Randomized scoreboard bench for sub_serial: stimulus pushes expected results,
// an independent monitor pops and compares on each rising done.
module tb_sub_serial;
    import serial_arith_pkg::*;

    localparam int W = DEF_WIDTH;

    typedef struct {
        logic [W-1:0] out;
        logic         borrow;
        int           start;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_serial_if #(.WIDTH(W)) bus ();

    sub_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain integer subtraction wrapped to W bits.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int start);
        exp_t e;
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = d + (1 << W);
        e.out    = W'(d);
        e.borrow = (a < b);
        e.start  = start;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called right after a negedge; returns at the negedge following the load edge.
    task automatic start_op(input int unsigned a, input int unsigned b, input bit track);
        bus.a  = W'(a);
        bus.b  = W'(b);
        bus.en = 1'b1;
        if (track) q.push_back(model(a & ((1 << W) - 1), b & ((1 << W) - 1), cyc + 1));
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit scramble);
        int n = 0;
        while (!bus.done && n < limit) begin
            if (scramble) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: done still 0 after %0d cycles, expected 1", limit);
        end
    endtask

    task automatic release_done();
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bus.done && !prev) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: done rose with empty scoreboard at cycle %0d", cyc);
                    end else begin
                        e = q.pop_front();
                        check("out", 32'(bus.out), 32'(e.out));
                        check("borrow", 32'(bus.borrow), 32'(e.borrow));
                        check("latency", 32'(cyc - e.start), 32'(W));
                    end
                end
                prev = bus.done;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst    = 1'b1;
        bus.en = 1'b0;
        bus.a  = '0;
        bus.b  = '0;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(bus.out), 32'h0);
        check("reset_borrow", 32'(bus.borrow), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 200 - 100, then hold in DONE and acknowledge.
        start_op(200, 100, 1'b1);
        wait_done(4 * W, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_out", 32'(bus.out), 32'h64);
            check("hold_done", 32'(bus.done), 32'h1);
        end
        release_done();
        check("ack_done", 32'(bus.done), 32'h0);
        check("ack_out", 32'(bus.out), 32'h64);
        repeat (3) begin
            @(negedge clk);
            check("idle_out", 32'(bus.out), 32'h64);
        end

        start_op(5, 7, 1'b1);
        check("load_clears_out", 32'(bus.out), 32'h0);
        wait_done(4 * W, 1'b0);
        release_done();
        start_op(0, 0, 1'b1);
        wait_done(4 * W, 1'b0);
        release_done();

        // Operand inputs change every cycle while the operation runs.
        start_op(8'h80, 8'h01, 1'b1);
        wait_done(4 * W, 1'b1);
        release_done();

        // en tied high: DONE->IDLE then immediate reload, W+2 edges between loads.
        bus.a  = W'(8'h10);
        bus.b  = W'(8'h20);
        bus.en = 1'b1;
        q.push_back(model(8'h10, 8'h20, cyc + 1));
        q.push_back(model(8'h10, 8'h20, cyc + 1 + W + 2));
        repeat (W + 3) @(negedge clk);
        bus.en = 1'b0;
        wait_done(4 * W, 1'b0);
        release_done();

        // Asynchronous reset during the 4th SUB cycle.
        start_op(8'hFF, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("partial_out", 32'(bus.out), 32'hE0);
        rst = 1'b1;
        #1;
        check("async_rst_out", 32'(bus.out), 32'h0);
        check("async_rst_borrow", 32'(bus.borrow), 32'h0);
        check("async_rst_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", 32'(bus.done), 32'h0);
        start_op(9, 3, 1'b1);
        wait_done(4 * W, 1'b0);
        release_done();

        // Randomized operations with random dwell in DONE and idle gaps.
        for (int i = 0; i < 40; i++) begin
            int unsigned ra, rb;
            ra = $urandom_range((1 << W) - 1, 0);
            rb = $urandom_range((1 << W) - 1, 0);
            start_op(ra, rb, 1'b1);
            wait_done(4 * W, 1'($urandom_range(1, 0)));
            repeat ($urandom_range(3, 0)) @(negedge clk);
            release_done();
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
